apb_slave_regfile: RTL
======================

APB_SLAVE_REGFILE -- requirements
Module: apb_slave_regfile

Interface
REQ-001 Parameter WDATA, default 8, data bus width in bits.
REQ-002 Parameter WADDR, default 8, address bus width in bits.
REQ-003 Parameter DEPTH, default 16, number of WDATA-wide registers; legal range 1..2^WADDR.
REQ-004 Parameter WAIT_CYCLES, default 2, number of access cycles with PREADY low before completion; legal range 0..15.
REQ-005 i_PCLK input 1 -- the single clock; all logic on its rising edge.
REQ-006 i_PRESETn input 1 -- reset, synchronous, active-low.
REQ-007 i_PSELx input 1 -- slave select from the APB master.
REQ-008 i_PENABLE input 1 -- access-phase indicator.
REQ-009 i_PWRITE input 1 -- 1 = write, 0 = read.
REQ-010 i_PADDR input WADDR -- register index.
REQ-011 i_PWDATA input WDATA -- write data.
REQ-012 o_PREADY output 1 -- transfer completion, registered.
REQ-013 o_PRDATA output WDATA -- read data, registered.
REQ-014 o_PSLVERR output 1 -- transfer error, registered, valid only while o_PREADY=1.

Function
REQ-015 FSM states: IDLE, WAIT, RESP; encoding 2 bits; any unused code SHALL go to IDLE on the next edge.
REQ-016 IDLE: on an edge sampling i_PSELx=1 and i_PENABLE=0 (setup phase), latch i_PADDR, i_PWRITE and i_PWDATA, load the wait counter with WAIT_CYCLES, and go to WAIT if WAIT_CYCLES>0, else to RESP.
REQ-017 WAIT: o_PREADY=0; counter decrements each edge; on the edge where the counter equals 1, go to RESP.
REQ-018 On the edge entering RESP: o_PREADY<=1; o_PSLVERR<=1 if the latched address is >= DEPTH, else 0; for a read, o_PRDATA<=reg[latched address], or 0 on error.
REQ-019 RESP: on the next edge, o_PREADY<=0, o_PSLVERR<=0, go to IDLE; a write commits reg[latched address]<=latched wdata at this edge only if there is no error.
REQ-020 Transfer length SHALL be 2+WAIT_CYCLES cycles (setup + access); WAIT_CYCLES=0 gives a zero-wait-state transfer.
REQ-021 o_PRDATA SHALL hold its last value outside RESP; a write transfer SHALL NOT change o_PRDATA.
REQ-022 Abort: if i_PSELx=0 is sampled in WAIT, return to IDLE, with no write, o_PREADY=0 and o_PSLVERR=0.
REQ-023 Back-to-back: a setup phase sampled in the cycle immediately after RESP SHALL be accepted from IDLE with no lost cycle.
REQ-024 Write data and address SHALL come from the latched setup values; changes on i_PADDR/i_PWDATA during WAIT are ignored.
REQ-025 An erroring write SHALL leave every register unchanged.

Reset
REQ-026 While i_PRESETn=0 at an edge: state<=IDLE, counter<=0, o_PREADY<=0, o_PSLVERR<=0, o_PRDATA<=0, all DEPTH registers<=0.
REQ-027 Reset asserted mid-transfer (WAIT or RESP) SHALL abandon the transfer, with no write committed.

Structure
REQ-028 The shared package SHALL hold the FSM state constants (IDLE/WAIT/RESP) and the default WDATA/WADDR values common to master and slave.
REQ-029 Register storage SHALL be one sub-module, apb_slave_mem: DEPTH x WDATA, synchronous write with enable, combinational read, synchronous reset-to-zero.

Verification
REQ-030 WAIT_CYCLES=2: write 0xA5 to addr 0x03 -> o_PREADY high exactly in the 3rd access cycle, o_PSLVERR=0; a following read of 0x03 returns o_PRDATA=0xA5 with o_PREADY.
REQ-031 WAIT_CYCLES=0: back-to-back write 0x11 to 0x00, then read 0x00 -> each transfer completes in 2 cycles; read returns 0x11.
REQ-032 Write 0x77 to addr 0x20 (>= DEPTH=16) -> o_PSLVERR=1 with o_PREADY; a read of 0x20 returns o_PRDATA=0, o_PSLVERR=1; no in-range register changes.
REQ-033 Drop i_PSELx during WAIT of a write of 0x5A to 0x05 -> return to IDLE, o_PREADY never high; reading 0x05 returns 0x00.
REQ-034 Assert i_PRESETn=0 in RESP of a write of 0xFF to 0x02 -> outputs 0 next cycle; reading 0x02 returns 0x00.
REQ-035 Change i_PADDR from 0x04 to 0x06 during WAIT of a write of 0x3C -> reg 0x04=0x3C, reg 0x06=0x00.

Source files
------------

// File: rtl/apb_slave_regfile_pkg.sv
// rtl/apb_slave_regfile_pkg.sv - shared APB defaults and slave FSM state encoding
package apb_slave_regfile_pkg;

  localparam int APB_WDATA_DEF = 8;
  localparam int APB_WADDR_DEF = 8;
  localparam int CNT_W         = 4;

  // 2'b11 is deliberately unused; the FSM folds it back to IDLE
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_RESP = 2'b10
  } state_e;

endpackage

// File: rtl/apb_slave_mem.sv
// rtl/apb_slave_mem.sv - DEPTH x WDATA register storage, sync write, comb read, sync clear
module apb_slave_mem #(
  parameter int WDATA = 8,
  parameter int WADDR = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             we,
  input  logic [WADDR-1:0] waddr,
  input  logic [WDATA-1:0] wdata,
  input  logic [WADDR-1:0] raddr,
  output logic [WDATA-1:0] rdata
);
  localparam int             IW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [WADDR:0] DEPTH_L = (WADDR+1)'(DEPTH);

  logic [WDATA-1:0] mem_q [DEPTH];
  logic [WDATA-1:0] mem_d [DEPTH];

  function automatic logic in_range(input logic [WADDR-1:0] a);
    return ({1'b0, a} < DEPTH_L);
  endfunction

  always_comb begin
    mem_d = mem_q;
    if (we && in_range(waddr)) begin
      mem_d[waddr[IW-1:0]] = wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      mem_q <= '{default: '0};
    end else begin
      mem_q <= mem_d;
    end
  end

  // out-of-range reads return zero rather than aliasing onto a real register
  assign rdata = in_range(raddr) ? mem_q[raddr[IW-1:0]] : '0;

endmodule

// File: rtl/apb_slave_regfile.sv
// rtl/apb_slave_regfile.sv - APB register-file slave with a fixed number of wait states
module apb_slave_regfile
  import apb_slave_regfile_pkg::*;
#(
  parameter int WDATA       = APB_WDATA_DEF,
  parameter int WADDR       = APB_WADDR_DEF,
  parameter int DEPTH       = 16,
  parameter int WAIT_CYCLES = 2
) (
  input  logic             i_PCLK,
  input  logic             i_PRESETn,
  input  logic             i_PSELx,
  input  logic             i_PENABLE,
  input  logic             i_PWRITE,
  input  logic [WADDR-1:0] i_PADDR,
  input  logic [WDATA-1:0] i_PWDATA,
  output logic             o_PREADY,
  output logic [WDATA-1:0] o_PRDATA,
  output logic             o_PSLVERR
);
  localparam logic [WADDR:0]   DEPTH_L = (WADDR+1)'(DEPTH);
  localparam logic [CNT_W-1:0] WAIT_L  = CNT_W'(WAIT_CYCLES);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WADDR-1:0] addr_q, addr_d;
  logic             write_q, write_d;
  logic [WDATA-1:0] wdata_q, wdata_d;
  logic             pready_q, pready_d;
  logic             pslverr_q, pslverr_d;
  logic [WDATA-1:0] prdata_q, prdata_d;

  logic             setup;
  logic             enter_resp;
  logic             mem_we;
  logic [WADDR-1:0] rd_addr;
  logic             rd_err;
  logic             wr_err;
  logic [WDATA-1:0] mem_rdata;

  // zero-wait transfers enter RESP straight from IDLE, so the live address is checked there
  assign rd_addr = (state_q == ST_IDLE) ? i_PADDR : addr_q;
  assign rd_err  = ({1'b0, rd_addr} >= DEPTH_L);
  assign wr_err  = ({1'b0, addr_q} >= DEPTH_L);
  assign setup   = i_PSELx && !i_PENABLE;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    write_d    = write_q;
    wdata_d    = wdata_q;
    pready_d   = 1'b0;
    pslverr_d  = 1'b0;
    prdata_d   = prdata_q;
    mem_we     = 1'b0;
    enter_resp = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (setup) begin
          addr_d  = i_PADDR;
          write_d = i_PWRITE;
          wdata_d = i_PWDATA;
          cnt_d   = WAIT_L;
          if (WAIT_CYCLES > 0) begin
            state_d = ST_WAIT;
          end else begin
            enter_resp = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        if (!i_PSELx) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - ONE;
          if (cnt_q == ONE) begin
            enter_resp = 1'b1;
          end
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
        mem_we  = write_q && !wr_err;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (enter_resp) begin
      state_d   = ST_RESP;
      pready_d  = 1'b1;
      pslverr_d = rd_err;
      if (!write_d) begin
        prdata_d = rd_err ? '0 : mem_rdata;
      end
    end
  end

  always_ff @(posedge i_PCLK) begin
    if (!i_PRESETn) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      write_q   <= 1'b0;
      wdata_q   <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      write_q   <= write_d;
      wdata_q   <= wdata_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      prdata_q  <= prdata_d;
    end
  end

  apb_slave_mem #(
    .WDATA(WDATA),
    .WADDR(WADDR),
    .DEPTH(DEPTH)
  ) u_mem (
    .clk   (i_PCLK),
    .resetn(i_PRESETn),
    .we    (mem_we),
    .waddr (addr_q),
    .wdata (wdata_q),
    .raddr (rd_addr),
    .rdata (mem_rdata)
  );

  assign o_PREADY  = pready_q;
  assign o_PSLVERR = pslverr_q;
  assign o_PRDATA  = prdata_q;

endmodule
